seg_pwr_seq: RTL and testbench

Power-up and enable sequencer for the Segway datapath. It runs from the synchronized reset and steps the platform through a fixed order: inertial sensor init, settle, gyro calibration, then balance-controller enable, then motor PWM enable. It watches overcurrent and low-battery faults and drives every enable to its safe level when one occurs. It is the only block allowed to assert `ctrl_en` and `pwm_en`.

---
 rtl/seg_pwr_seq.sv | 157 +++++++++++++++
 tb/tb_seg_pwr_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_pwr_seq.sv
// Power-up / enable sequencer for the Segway datapath: sensor init, settle, gyro cal,
// then controller enable ahead of motor PWM, with fault shutdown and rider re-arm.
module seg_pwr_seq #(
    parameter int unsigned INIT_TMO   = 65536,
    parameter int unsigned SETTLE_CYC = 1024,
    parameter int unsigned FAULT_HOLD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_up,
    input  logic       ovr_I,
    input  logic       batt_low,
    input  logic       sns_done,
    input  logic       cal_done,
    output logic       sns_init_req,
    output logic       cal_req,
    output logic       ctrl_en,
    output logic       pwm_en,
    output logic [2:0] state_o,
    output logic [1:0] fault_code
);

    localparam int unsigned MAX_AB = (INIT_TMO > SETTLE_CYC) ? INIT_TMO : SETTLE_CYC;
    localparam int unsigned MAX_P  = (MAX_AB > FAULT_HOLD) ? MAX_AB : FAULT_HOLD;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] TMO_LAST    = CW'(INIT_TMO - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(FAULT_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVR  = 2'b01;
    localparam logic [1:0] FC_BATT = 2'b10;
    localparam logic [1:0] FC_TMO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_SNS_INIT = 3'b001,
        ST_SETTLE   = 3'b010,
        ST_CAL      = 3'b011,
        ST_RUN      = 3'b100,
        ST_STOP     = 3'b101,
        ST_FAULT    = 3'b110
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    code_q, code_d;
    logic          sns_init_req_q, sns_init_req_d;
    logic          cal_req_q, cal_req_d;
    logic          ctrl_en_q, ctrl_en_d;
    logic          pwm_en_q, pwm_en_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pwr_up && !ovr_I && !batt_low) begin
                    state_d = ST_SNS_INIT;
                end
            end
            ST_SNS_INIT: begin
                if (sns_done) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TMO;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAL;
                end
            end
            ST_CAL: begin
                if (cal_done) begin
                    state_d = ST_RUN;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TMO;
                end
            end
            ST_RUN: begin
                if (!pwr_up) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if ((cnt_q >= HOLD_LAST) && !pwr_up && !ovr_I && !batt_low) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Live faults override every normal transition, including a timeout in the same cycle.
        if ((state_q != ST_IDLE) && (state_q != ST_FAULT) && (ovr_I || batt_low)) begin
            state_d = ST_FAULT;
            code_d  = ovr_I ? FC_OVR : FC_BATT;
        end

        if ((state_q == ST_IDLE) && (state_d == ST_SNS_INIT)) begin
            code_d = FC_NONE;
        end
    end

    // Saturating so a long FAULT dwell can never wrap back below the hold threshold.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_comb begin
        sns_init_req_d = (state_d == ST_SNS_INIT);
        cal_req_d      = (state_d == ST_CAL) && (state_q != ST_CAL);
        ctrl_en_d      = (state_d == ST_RUN) || (state_d == ST_STOP);
        pwm_en_d       = (state_d == ST_RUN) && (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            code_q         <= FC_NONE;
            sns_init_req_q <= 1'b0;
            cal_req_q      <= 1'b0;
            ctrl_en_q      <= 1'b0;
            pwm_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            code_q         <= code_d;
            sns_init_req_q <= sns_init_req_d;
            cal_req_q      <= cal_req_d;
            ctrl_en_q      <= ctrl_en_d;
            pwm_en_q       <= pwm_en_d;
        end
    end

    assign sns_init_req = sns_init_req_q;
    assign cal_req      = cal_req_q;
    assign ctrl_en      = ctrl_en_q;
    assign pwm_en       = pwm_en_q;
    assign state_o      = state_q;
    assign fault_code   = code_q;

endmodule

// File: tb/tb_seg_pwr_seq.sv
// Directed bench for seg_pwr_seq with short timing parameters and hand-computed expectations.
module tb_seg_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       pwr_up;
    logic       ovr_I;
    logic       batt_low;
    logic       sns_done;
    logic       cal_done;
    logic       sns_init_req;
    logic       cal_req;
    logic       ctrl_en;
    logic       pwm_en;
    logic [2:0] state_o;
    logic [1:0] fault_code;

    int n_vec = 0;
    int n_err = 0;

    seg_pwr_seq #(
        .INIT_TMO   (32),
        .SETTLE_CYC (8),
        .FAULT_HOLD (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwr_up       (pwr_up),
        .ovr_I        (ovr_I),
        .batt_low     (batt_low),
        .sns_done     (sns_done),
        .cal_done     (cal_done),
        .sns_init_req (sns_init_req),
        .cal_req      (cal_req),
        .ctrl_en      (ctrl_en),
        .pwm_en       (pwm_en),
        .state_o      (state_o),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic sir, input logic cr, input logic ce,
                       input logic pe, input logic [2:0] st, input logic [1:0] fc);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {sns_init_req, cal_req, ctrl_en, pwm_en, state_o, fault_code};
        exp = {sir, cr, ce, pe, st, fc};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {sir,cr,ce,pe,st,fc}=%b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pwr_up   = 1'b0;
        ovr_I    = 1'b0;
        batt_low = 1'b0;
        sns_done = 1'b0;
        cal_done = 1'b0;
        step();
        step();
        chk("reset", 0, 0, 0, 0, 3'b000, 2'b00);
        rst_n = 1'b1;
        step();
        chk("idle_hold", 0, 0, 0, 0, 3'b000, 2'b00);

        // fault input in IDLE blocks the start without entering FAULT
        pwr_up   = 1'b1;
        batt_low = 1'b1;
        step();
        chk("idle_block", 0, 0, 0, 0, 3'b000, 2'b00);
        batt_low = 1'b0;
        step();
        chk("sns_entry", 1, 0, 0, 0, 3'b001, 2'b00);

        // normal start
        repeat (4) step();
        chk("sns_wait", 1, 0, 0, 0, 3'b001, 2'b00);
        sns_done = 1'b1;
        step();
        sns_done = 1'b0;
        chk("settle_entry", 0, 0, 0, 0, 3'b010, 2'b00);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("settle_wait", 0, 0, 0, 0, 3'b010, 2'b00);
        end
        step();
        chk("cal_pulse", 0, 1, 0, 0, 3'b011, 2'b00);
        step();
        chk("cal_one_shot", 0, 0, 0, 0, 3'b011, 2'b00);
        step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("ctrl_first", 0, 0, 1, 0, 3'b100, 2'b00);
        step();
        chk("pwm_second", 0, 0, 1, 1, 3'b100, 2'b00);
        step();
        chk("run_steady", 0, 0, 1, 1, 3'b100, 2'b00);

        // orderly stop
        pwr_up = 1'b0;
        step();
        chk("stop", 0, 0, 1, 0, 3'b101, 2'b00);
        step();
        chk("stop_idle", 0, 0, 0, 0, 3'b000, 2'b00);

        // sensor timeout
        pwr_up = 1'b1;
        step();
        chk("tmo_entry", 1, 0, 0, 0, 3'b001, 2'b00);
        repeat (31) step();
        chk("tmo_last_cycle", 1, 0, 0, 0, 3'b001, 2'b00);
        step();
        chk("tmo_fault", 0, 0, 0, 0, 3'b110, 2'b11);
        repeat (30) step();
        chk("tmo_no_rearm", 0, 0, 0, 0, 3'b110, 2'b11);
        pwr_up = 1'b0;
        step();
        chk("tmo_exit", 0, 0, 0, 0, 3'b000, 2'b11);

        // overcurrent in RUN with pwr_up dropped at once
        pwr_up = 1'b1;
        step();
        sns_done = 1'b1;
        step();
        sns_done = 1'b0;
        repeat (8) step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        step();
        chk("run_again", 0, 0, 1, 1, 3'b100, 2'b00);
        ovr_I  = 1'b1;
        pwr_up = 1'b0;
        step();
        ovr_I = 1'b0;
        chk("ovr_fault", 0, 0, 0, 0, 3'b110, 2'b01);
        repeat (15) step();
        chk("ovr_hold_min", 0, 0, 0, 0, 3'b110, 2'b01);
        step();
        chk("ovr_hold_exit", 0, 0, 0, 0, 3'b000, 2'b01);

        // battery low in SETTLE
        pwr_up = 1'b1;
        step();
        sns_done = 1'b1;
        step();
        sns_done = 1'b0;
        step();
        batt_low = 1'b1;
        step();
        chk("batt_fault", 0, 0, 0, 0, 3'b110, 2'b10);
        batt_low = 1'b0;
        pwr_up   = 1'b0;
        repeat (16) step();
        chk("batt_exit", 0, 0, 0, 0, 3'b000, 2'b10);

        // simultaneous cal_done, batt_low and ovr_I in CAL
        pwr_up = 1'b1;
        step();
        sns_done = 1'b1;
        step();
        sns_done = 1'b0;
        repeat (8) step();
        chk("cal_reach", 0, 1, 0, 0, 3'b011, 2'b00);
        cal_done = 1'b1;
        batt_low = 1'b1;
        ovr_I    = 1'b1;
        step();
        chk("simul_fault", 0, 0, 0, 0, 3'b110, 2'b01);
        cal_done = 1'b0;
        batt_low = 1'b0;
        ovr_I    = 1'b0;
        pwr_up   = 1'b0;
        step();
        chk("simul_no_run", 0, 0, 0, 0, 3'b110, 2'b01);
        repeat (15) step();
        chk("simul_exit", 0, 0, 0, 0, 3'b000, 2'b01);

        // asynchronous reset mid-SETTLE
        pwr_up = 1'b1;
        step();
        sns_done = 1'b1;
        step();
        sns_done = 1'b0;
        repeat (3) step();
        chk("settle_pre_rst", 0, 0, 0, 0, 3'b010, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 0, 0, 0, 0, 3'b000, 2'b00);
        step();
        step();
        rst_n = 1'b1;
        chk("rst_held", 0, 0, 0, 0, 3'b000, 2'b00);
        step();
        chk("restart", 1, 0, 0, 0, 3'b001, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
